// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC source encoding for the fetch PC unit
package pc_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int PC_INCR    = 4;
    localparam int BR_SHIFT   = 2;

    typedef enum logic [2:0] {
        SRC_STEP,
        SRC_BR,
        SRC_RET,
        SRC_REDIR,
        SRC_HOLD
    } next_src_e;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module return_stack #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W:0]    count;

    assign top   = mem[top_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push && pop) begin
            count <= count;
        end else if (push) begin
            // Advancing past a full stack lands on the oldest slot, which the write below reclaims
            top_ptr <= top_ptr + 1'b1;
            if (!full)
                count <= count + 1'b1;
        end else if (pop) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
        end
    end

    // Entry storage is not cleared by reset; count alone defines validity
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push && pop)
                mem[top_ptr] <= data;
            else if (push)
                mem[top_ptr + 1'b1] <= data;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch-stage next-PC selection with stall, redirect and return-address stack
module fetch_pc_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                COND_W    = 19,
    parameter int                BR_W      = 26,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              br_taken,
    input  logic              uncondbr,
    input  logic [COND_W-1:0] cond_addr,
    input  logic [BR_W-1:0]   br_addr,
    input  logic              link,
    input  logic              ret,
    input  logic [ADDR_W-1:0] ret_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovfl,
    output logic              ras_unfl
);

    next_src_e         next_src;
    logic [ADDR_W-1:0] cond_off;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_push;
    logic              ras_pop;

    assign cond_off  = {{(ADDR_W-COND_W){cond_addr[COND_W-1]}}, cond_addr};
    assign br_off    = {{(ADDR_W-BR_W){br_addr[BR_W-1]}}, br_addr};
    assign br_target = pc + ((uncondbr ? br_off : cond_off) << BR_SHIFT);
    assign pc_plus4  = pc + ADDR_W'(PC_INCR);

    always_comb begin
        next_src = SRC_STEP;
        if (redirect)
            next_src = SRC_REDIR;
        else if (stall)
            next_src = SRC_HOLD;
        else if (ret)
            next_src = SRC_RET;
        else if (br_taken)
            next_src = SRC_BR;
    end

    // A BL alongside a RET still records its link value, replacing the popped top
    assign ras_push = link && br_taken && (next_src == SRC_BR || next_src == SRC_RET);
    assign ras_pop  = (next_src == SRC_RET) && !ras_empty;

    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .data  (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            ras_ovfl <= 1'b0;
            ras_unfl <= 1'b0;
        end else begin
            case (next_src)
                SRC_STEP:  pc <= pc_plus4;
                SRC_BR:    pc <= br_target;
                SRC_RET:   pc <= ras_empty ? ret_target : ras_top;
                SRC_REDIR: pc <= redirect_pc;
                SRC_HOLD:  pc <= pc;
                default:   pc <= pc_plus4;
            endcase
            if (ras_push && ras_full && !ras_pop)
                ras_ovfl <= 1'b1;
            if (next_src == SRC_RET && ras_empty)
                ras_unfl <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed table-driven bench for fetch_pc_unit
module tb_fetch_pc_unit;

    localparam logic [63:0] RT = 64'h0000_0000_000D_EAD0;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, br_taken, uncondbr, link, ret;
    logic [63:0] redirect_pc, ret_target, pc, pc_plus4;
    logic [18:0] cond_addr;
    logic [25:0] br_addr;
    logic        ras_empty, ras_full, ras_ovfl, ras_unfl;

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .br_taken    (br_taken),
        .uncondbr    (uncondbr),
        .cond_addr   (cond_addr),
        .br_addr     (br_addr),
        .link        (link),
        .ret         (ret),
        .ret_target  (ret_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .ras_ovfl    (ras_ovfl),
        .ras_unfl    (ras_unfl)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [63:0] rpc;
        logic        stl;
        logic        bt;
        logic        unc;
        logic [18:0] ca;
        logic [25:0] ba;
        logic        lk;
        logic        rt;
        logic [63:0] epc;
        logic        ee;
        logic        ef;
        logic        eo;
        logic        eu;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(logic rst, logic redir, logic [63:0] rpc, logic stl,
                                logic bt, logic unc, logic [18:0] ca, logic [25:0] ba,
                                logic lk, logic rt, logic [63:0] epc,
                                logic ee, logic ef, logic eo, logic eu);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.stl = stl; v.bt = bt; v.unc = unc;
        v.ca = ca; v.ba = ba; v.lk = lk; v.rt = rt;
        v.epc = epc; v.ee = ee; v.ef = ef; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run(vec_t v, string tag);
        @(negedge clk);
        reset = v.rst; redirect = v.redir; redirect_pc = v.rpc; stall = v.stl;
        br_taken = v.bt; uncondbr = v.unc; cond_addr = v.ca; br_addr = v.ba;
        link = v.lk; ret = v.rt; ret_target = RT;
        @(posedge clk);
        #1;
        chk({tag, "_pc"}, pc, v.epc);
        chk({tag, "_pc4"}, pc_plus4, v.epc + 64'd4);
        chk({tag, "_empty"}, 64'(ras_empty), 64'(v.ee));
        chk({tag, "_full"}, 64'(ras_full), 64'(v.ef));
        chk({tag, "_ovfl"}, 64'(ras_ovfl), 64'(v.eo));
        chk({tag, "_unfl"}, 64'(ras_unfl), 64'(v.eu));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; br_taken = 1'b0;
        uncondbr = 1'b0; cond_addr = '0; br_addr = '0; link = 1'b0; ret = 1'b0; ret_target = RT;

        //            rst rd rpc          st bt un ca          ba        lk rt  epc        e f o u
        vecs.push_back(mk(1, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h0,     1,0,0,0));
        vecs.push_back(mk(1, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h0,     1,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h4,     1,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h8,     1,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 0, 64'hC,     1,0,0,0));
        vecs.push_back(mk(0, 1, 64'h40,   0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h40,    1,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 0, 19'h7FFFE, 26'h0,    0, 0, 64'h38,    1,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h10,   0, 0, 64'h78,    1,0,0,0));
        vecs.push_back(mk(0, 1, 64'h100,  0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h100,   1,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 0, 64'h200,   0,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 1, 64'h104,   1,0,0,0));
        vecs.push_back(mk(0, 1, 64'h100,  0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h100,   1,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 0, 64'h200,   0,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 0, 64'h300,   0,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 0, 64'h400,   0,0,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 0, 64'h500,   0,1,0,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 0, 64'h600,   0,1,1,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 1, 64'h504,   0,0,1,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 1, 64'h404,   0,0,1,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 1, 64'h304,   0,0,1,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 1, 64'h204,   1,0,1,0));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 1, RT,        1,0,1,1));
        vecs.push_back(mk(0, 1, 64'h1000, 0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h1000,  1,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 0, 64'h1100,  0,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    1, 1, 1, 19'h0,     26'h10,   1, 1, 64'h1100,  0,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    1, 1, 0, 19'h7FFFE, 26'h0,    0, 0, 64'h1100,  0,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    1, 1, 1, 19'h0,     26'h10,   1, 0, 64'h1100,  0,0,1,1));
        vecs.push_back(mk(0, 1, 64'h8000, 1, 1, 1, 19'h0,     26'h10,   1, 1, 64'h8000,  0,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 1, 64'h1004,  1,0,1,1));
        vecs.push_back(mk(0, 1, 64'h2000, 0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h2000,  1,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 0, 64'h2100,  0,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    0, 1, 1, 19'h0,     26'h40,   1, 1, 64'h2004,  0,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 1, 64'h2104,  1,0,1,1));
        vecs.push_back(mk(0, 1, 64'h3000, 0, 1, 1, 19'h0,     26'h40,   1, 1, 64'h3000,  1,0,1,1));
        vecs.push_back(mk(0, 0, 64'h0,    0, 0, 0, 19'h0,     26'h0,    0, 0, 64'h3004,  1,0,1,1));

        foreach (vecs[i])
            run(vecs[i], $sformatf("v%0d", i));

        // Address wrap, then reset with three live RAS entries and both sticky flags set
        run(mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 19'h0, 26'h0, 0, 0,
               64'hFFFF_FFFF_FFFF_FFFC, 1,0,1,1), "wrap_set");
        run(mk(0, 0, 64'h0, 0, 0, 0, 19'h0, 26'h0, 0, 0, 64'h0, 1,0,1,1), "wrap_step");
        run(mk(0, 0, 64'h0, 0, 1, 1, 19'h0, 26'h40, 1, 0, 64'h100, 0,0,1,1), "rst_push1");
        run(mk(0, 0, 64'h0, 0, 1, 1, 19'h0, 26'h40, 1, 0, 64'h200, 0,0,1,1), "rst_push2");
        run(mk(0, 0, 64'h0, 0, 1, 1, 19'h0, 26'h40, 1, 0, 64'h300, 0,0,1,1), "rst_push3");
        run(mk(1, 1, 64'h9000, 1, 1, 1, 19'h0, 26'h40, 1, 1, 64'h0, 1,0,0,0), "mid_reset");
        run(mk(0, 0, 64'h0, 0, 0, 0, 19'h0, 26'h0, 0, 1, RT, 1,0,0,1), "post_reset_ret");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
